cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Run-control sequencer and program-RAM owner for the 4-bit-address/8-bit-data accumulator CPU. Holds the 16x8 program RAM and arbitrates it between the Wishbone host (program load, readback) and the CPU core fetch/execute port. Sequences the core through reset, free-run, single-step and halt via cpu_rst_o/cpu_clk_en_o, and raises an interrupt on halt or step completion.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base; decode uses wbs_adr_i[31:8] == BASE_ADDR[31:8]
ADDR_W, 4, RAM address width (depth 2**ADDR_W)
DATA_W, 8, RAM word width
STEP_CYCLES, 2, core clock-enable cycles per single step (one instruction)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_stb_i/wbs_cyc_i/wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
wbs_sel_i  in  4  byte selects; only sel[0] gates RAM/CTRL writes
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack
wbs_dat_o  out  32  read data
cpu_req_i  in  1  core RAM access request
cpu_we_i  in  1  core write (STA)
cpu_addr_i  in  ADDR_W  core address
cpu_wdata_i  in  DATA_W  core write data
cpu_gnt_o  out  1  core access granted this cycle
cpu_rdata_o  out  DATA_W  RAM[cpu_addr_i], combinational read
cpu_halted_i  in  1  core executed HLT
cpu_rst_o  out  1  core reset
cpu_clk_en_o  out  1  core advance enable
irq_o  out  1  level interrupt

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE, cpu_rst_o=1, cpu_clk_en_o=0, cpu_gnt_o=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, CTRL=0, STATUS sticky bits=0. RAM contents not reset.
- Map (offset = adr[7:0]): 0x00-0x3C RAM word adr[5:2], data[DATA_W-1:0]; 0x40 CTRL; 0x44 STATUS; 0x48 CYCCNT (optional).
- CTRL bits: [0] run, [1] step (write-1 pulse, reads 0), [2] irq_en_halt, [3] irq_en_step.
- STATUS: [2:0] state code (IDLE=0, RUN=1, STEP=2, HALTED=3), [3] halted sticky, [4] step_done sticky; write-1-to-clear [4:3].
- Wishbone: access accepted when stb&cyc&decode hit and RAM slot free; wbs_ack_o high exactly one cycle, the cycle after acceptance; read data valid with ack; no back-to-back ack without stb re-sample. Decode miss: never acked.
- Arbitration: single-port RAM. CPU priority when cpu_clk_en_o=1 and cpu_req_i=1 (cpu_gnt_o=1). Host RAM access accepted only in cycles with cpu_gnt_o=0; in IDLE/HALTED host always wins. CTRL/STATUS accesses never stall.
- Simultaneous CPU and host write to same address: CPU write lands, host access stalls one cycle then overwrites.
- FSM:
  IDLE: cpu_rst_o=1, clk_en=0. run=1 -> RUN; step pulse -> STEP.
  RUN: cpu_rst_o=0, clk_en=1. cpu_halted_i -> HALTED (clk_en drops same edge, halted sticky set). run=0 -> IDLE.
  STEP: cpu_rst_o=0, clk_en=1 for exactly STEP_CYCLES cycles (counter), then -> PAUSE-in-HALTED code with step_done set; cpu_halted_i during step -> HALTED, halted set.
  HALTED: clk_en=0, cpu_rst_o=0 (core state observable). step pulse while not core-halted -> STEP; run=1 rising -> RUN; run=0 written with CTRL[2:0]=0 and halted -> IDLE.
- Step pulse ignored in RUN. run and step written together: run wins.
- irq_o = (halted&irq_en_halt) | (step_done&irq_en_step), registered, clears one cycle after W1C.
- Reset mid-step: all counters cleared, IDLE, no step_done.

Optional Feature:
CPU_RUN_CTRL_CYCCNT_EN: defined -> 16-bit CYCCNT at 0x48 counts cycles with cpu_clk_en_o=1, saturates at 0xFFFF, cleared on entry to IDLE and by any write. Undefined -> 0x48 reads 0, writes ignored, no counter logic.

Test Plan:
- Reset, write RAM[0..3]=0x51,0x80,0x90,0x00 via WB, read back -> each read acked 1 cycle later, data matches, cpu_rst_o=1.
- CTRL=0x5 (run, irq_en_halt); core asserts cpu_halted_i after 6 cycles -> clk_en falls next edge, STATUS=0x0B, irq_o=1; W1C 0x08 -> irq_o=0.
- From IDLE, CTRL=0x0A (step, irq_en_step) -> clk_en high exactly 2 cycles, STATUS[4]=1, irq_o=1, state code 3.
- RUN with cpu_req_i held 3 cycles, host read RAM[5] issued at cycle 0 -> ack on cycle 4, cpu_gnt_o=1 cycles 0-2.
- Same-cycle CPU write 0xAA and host write 0x55 to RAM[7] -> final RAM[7]=0x55, host ack delayed one cycle.
- Assert wb_rst_i mid-STEP (cycle 1) -> outputs at reset values immediately, STATUS=0 after release; with CPU_RUN_CTRL_CYCCNT_EN, CYCCNT=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer and program-RAM owner for the
// 4-bit-address / 8-bit-data accumulator CPU.
//
// The block owns a single-port program RAM and shares it between the
// Wishbone host and the core. It sequences the core through reset,
// free-run, single-step and halt, and raises a level interrupt on halt or
// step completion.
//
// Register map (byte offset inside the 256-byte window at BASE_ADDR):
//   0x00-0x3C  RAM word adr[5:2], data in bits [DATA_W-1:0]
//   0x40       CTRL   [0] run, [1] step (write-1 pulse, reads 0),
//                     [2] irq_en_halt, [3] irq_en_step
//   0x44       STATUS [2:0] state code, [3] halted sticky,
//                     [4] step_done sticky (write 1 to clear [4:3])
//   0x48       CYCCNT (only when CPU_RUN_CTRL_CYCCNT_EN is defined,
//                     otherwise reads 0 and ignores writes)
//
// Optional feature macro: CPU_RUN_CTRL_CYCCNT_EN adds a 16-bit saturating
// count of core clock-enable cycles at offset 0x48.
//
// Handshake: a host request is valid when stb & cyc & address hit and no
// ack is being returned this cycle. It is accepted (ready) when it targets a
// register, or targets the RAM in a cycle where the core holds no grant.
// wbs_ack_o is high for exactly the one cycle after acceptance, with read
// data valid alongside it. Addresses outside the window are never acked.
//
// The FSM state code is visible to software and checkers through STATUS[2:0].

module cpu_run_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ADDR_W      = 4,
    parameter int          DATA_W      = 8,
    parameter int          STEP_CYCLES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              cpu_halted_i,
    output logic              cpu_rst_o,
    output logic              cpu_clk_en_o,
    output logic              irq_o
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic              hit, is_ram, is_ctrl, is_stat, is_cyc;
    logic              req, accept, wr, wr0, ctrl_wr, stat_wr;
    logic [ADDR_W-1:0] host_idx;
    logic [31:0]       rd_data, cyccnt_rd;
    logic              ack_q, irq_q;
    logic [31:0]       dat_q;
    logic              run_q, en_halt_q, en_step_q;
    logic              step_pulse_q, run_rise_q, idle_req_q;
    logic              halted_s, step_s;
    logic              set_halted, set_step;
    logic [CNT_W-1:0]  step_cnt;
    logic              clk_en;
    logic              unused_bits;

    assign clk_en       = (state == ST_RUN) || (state == ST_STEP);
    assign cpu_clk_en_o = clk_en;
    assign cpu_rst_o    = (state == ST_IDLE);
    assign cpu_gnt_o    = clk_en & cpu_req_i;
    assign cpu_rdata_o  = ram[cpu_addr_i];
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign irq_o        = irq_q;
    assign host_idx     = wbs_adr_i[ADDR_W+1:2];
    assign unused_bits  = ^{wbs_dat_i, wbs_sel_i, wbs_adr_i[1:0]};

    // Address decode and host acceptance; RAM accesses yield to a core grant.
    always_comb begin
        hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        is_ram  = (wbs_adr_i[7:6] == 2'b00);
        is_ctrl = (wbs_adr_i[7:0] == 8'h40);
        is_stat = (wbs_adr_i[7:0] == 8'h44);
        is_cyc  = (wbs_adr_i[7:0] == 8'h48);
        req     = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
        accept  = req & (~is_ram | ~cpu_gnt_o);
        wr      = accept & wbs_we_i;
        wr0     = wr & wbs_sel_i[0];
        ctrl_wr = wr0 & is_ctrl;
        stat_wr = wr0 & is_stat;
    end

    // Read-data mux for the word addressed by the host.
    always_comb begin
        rd_data = '0;
        if (is_ram) begin
            rd_data = 32'(ram[host_idx]);
        end else if (is_ctrl) begin
            rd_data = {28'd0, en_step_q, en_halt_q, 1'b0, run_q};
        end else if (is_stat) begin
            rd_data = {27'd0, step_s, halted_s, state};
        end else if (is_cyc) begin
            rd_data = cyccnt_rd;
        end
    end

    // Wishbone ack and registered read data, one cycle after acceptance.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                dat_q <= wbs_we_i ? 32'd0 : rd_data;
            end
        end
    end

    // CTRL register plus one-cycle command pulses derived from CTRL writes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            run_q        <= 1'b0;
            en_halt_q    <= 1'b0;
            en_step_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            run_rise_q   <= 1'b0;
            idle_req_q   <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            run_rise_q   <= 1'b0;
            idle_req_q   <= 1'b0;
            if (ctrl_wr) begin
                run_q        <= wbs_dat_i[0];
                en_halt_q    <= wbs_dat_i[2];
                en_step_q    <= wbs_dat_i[3];
                step_pulse_q <= wbs_dat_i[1];
                run_rise_q   <= wbs_dat_i[0] & ~run_q;
                idle_req_q   <= (wbs_dat_i[2:0] == 3'b000);
            end
        end
    end

    // STATUS sticky bits: a new event wins over a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            halted_s <= 1'b0;
            step_s   <= 1'b0;
        end else begin
            if (set_halted) begin
                halted_s <= 1'b1;
            end else if (stat_wr && wbs_dat_i[3]) begin
                halted_s <= 1'b0;
            end
            if (set_step) begin
                step_s <= 1'b1;
            end else if (stat_wr && wbs_dat_i[4]) begin
                step_s <= 1'b0;
            end
        end
    end

    // Registered level interrupt from the enabled sticky bits.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (halted_s & en_halt_q) | (step_s & en_step_q);
        end
    end

    // Single-step length counter, running only while in STEP.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            step_cnt <= '0;
        end else if (state == ST_STEP) begin
            step_cnt <= step_cnt + 1'b1;
        end else begin
            step_cnt <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and sticky-set strobes.
    always_comb begin
        state_nx   = state;
        set_halted = 1'b0;
        set_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_q) begin
                    state_nx = ST_RUN;
                end else if (step_pulse_q) begin
                    state_nx = ST_STEP;
                end
            end
            ST_RUN: begin
                if (cpu_halted_i) begin
                    state_nx   = ST_HALTED;
                    set_halted = 1'b1;
                end else if (!run_q) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (cpu_halted_i) begin
                    state_nx   = ST_HALTED;
                    set_halted = 1'b1;
                end else if (step_cnt == STEP_LAST) begin
                    state_nx = ST_HALTED;
                    set_step = 1'b1;
                end
            end
            ST_HALTED: begin
                if (run_rise_q) begin
                    state_nx = ST_RUN;
                end else if (step_pulse_q && !cpu_halted_i) begin
                    state_nx = ST_STEP;
                end else if (idle_req_q) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Program RAM write port: the granted core first, otherwise the host.
    always_ff @(posedge wb_clk_i) begin
        if (cpu_gnt_o && cpu_we_i) begin
            ram[cpu_addr_i] <= cpu_wdata_i;
        end else if (wr0 && is_ram) begin
            ram[host_idx] <= wbs_dat_i[DATA_W-1:0];
        end
    end

`ifdef CPU_RUN_CTRL_CYCCNT_EN
    logic [15:0] cyccnt_q;

    // Saturating count of core-enabled cycles, cleared on IDLE entry or write.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyccnt_q <= '0;
        end else if ((wr && is_cyc) || (state_nx == ST_IDLE && state != ST_IDLE)) begin
            cyccnt_q <= '0;
        end else if (clk_en && cyccnt_q != 16'hFFFF) begin
            cyccnt_q <= cyccnt_q + 16'd1;
        end
    end

    assign cyccnt_rd = {16'd0, cyccnt_q};
`else
    assign cyccnt_rd = '0;
`endif

endmodule
